tt_sweep_checker: RTL and testbench

- Synthesizable hardware counterpart of the team's truth-table testbenches.
- Drives every input combination of an N_IN-input combinational DUT and waits a programmable settle time after each one.
- Samples the DUT's N_OUT outputs and compares them against a golden truth table given as a parameter.
- Reports pass/fail, the mismatch count and the first failing vector; used for on-board self-check of logic-gate exercises.

---
 rtl/tt_pkg.sv | 25 ++
 rtl/tt_sweep_checker_settle.sv | 28 ++
 rtl/tt_sweep_checker.sv | 122 ++++++++++++
 tb/tb_tt_sweep_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_pkg;

    localparam int unsigned TT_TABLE_MAX_W = 4096;
    localparam int unsigned TT_SLICE_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    // Returns the slice of a packed truth table for vector idx; caller truncates to n_out bits.
    function automatic logic [TT_SLICE_MAX_W-1:0] tt_slice(
        input logic [TT_TABLE_MAX_W-1:0] table_bits,
        input int unsigned               idx,
        input int unsigned               n_out
    );
        logic [TT_TABLE_MAX_W-1:0] shifted;
        shifted = table_bits >> (idx * n_out);
        return shifted[TT_SLICE_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/tt_sweep_checker_settle.sv
// Settle timer: tick is high once SETTLE cycles have elapsed since load.
module tt_settle_counter #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt;

    // Count 0..SETTLE-1 after each load and hold at the terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (cnt != CW'(SETTLE - 1)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 2**N_IN input vectors of a combinational DUT and checks its outputs
// against a golden truth table. Optional macro TT_CAPTURE_EN adds captured_table,
// which holds every observed response of the last sweep.
module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned SETTLE = 1,
    parameter logic [(1 << N_IN)*N_OUT-1:0] GOLDEN = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic [N_OUT-1:0]  resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     mismatch_count,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_idx
`ifdef TT_CAPTURE_EN
    ,
    output logic [(1 << N_IN)*N_OUT-1:0] captured_table
`endif
);

    localparam int unsigned N_VEC = 1 << N_IN;
    localparam int unsigned CNT_W = N_IN + 1;

    tt_state_t         state;
    logic [N_IN-1:0]   idx;
    logic              tick;
    logic              load_c;
    logic              last_c;
    logic              start_ok_c;
    logic              mis_c;
    logic [CNT_W-1:0]  mismatch_next_c;
    logic [N_OUT-1:0]  expected_c;

    // Golden slice, compare result and settle-timer reload for the current vector.
    assign expected_c      = N_OUT'(tt_slice(TT_TABLE_MAX_W'(GOLDEN), 32'(idx), N_OUT));
    assign mis_c           = (resp != expected_c);
    assign mismatch_next_c = mismatch_count + CNT_W'(mis_c);
    assign last_c          = (idx == N_IN'(N_VEC - 1));
    assign start_ok_c      = start && ((state == IDLE) || (state == DONE));
    assign load_c          = start_ok_c || ((state == SAMPLE) && !last_c);

    tt_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .tick (tick)
    );

    // Sweep FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= '0;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
`ifdef TT_CAPTURE_EN
            captured_table   <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= DRIVE;
                        idx              <= '0;
                        stim             <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        mismatch_count   <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_idx   <= '0;
`ifdef TT_CAPTURE_EN
                        captured_table   <= '0;
`endif
                    end
                end
                DRIVE: begin
                    if (tick) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    mismatch_count <= mismatch_next_c;
                    if (mis_c && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                    end
`ifdef TT_CAPTURE_EN
                    captured_table[32'(idx)*N_OUT +: N_OUT] <= resp;
`endif
                    if (last_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mismatch_next_c == '0);
                    end else begin
                        state <= DRIVE;
                        idx   <= idx + N_IN'(1);
                        stim  <= idx + N_IN'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: loopback, logic_ops exercise, stuck-at fault,
// mid-sweep reset, start while busy / from DONE, slow-settle instance, optional capture.
module tb_tt_sweep_checker;

    // Identity table: slice i = i.
    localparam logic [63:0] GOLDEN_ID  = 64'hFEDC_BA98_7654_3210;
    // logic_ops columns {AND1=A&B, AND2=C&D, OR=AND1|AND2, NOT D}, slice 15 first.
    localparam logic [63:0] GOLDEN_OPS = 64'hEBAB_6101_6101_6101;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic id_invert;
    logic ops_stuck;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] stim_ops, stim_id, stim_s3;
    logic [3:0] resp_ops, resp_id, resp_s3;
    logic       busy_ops, busy_id, busy_s3;
    logic       done_ops, done_id, done_s3;
    logic       pass_ops, pass_id, pass_s3;
    logic [4:0] mc_ops, mc_id, mc_s3;
    logic       ffv_ops, ffv_id, ffv_s3;
    logic [3:0] ffi_ops, ffi_id, ffi_s3;
`ifdef TT_CAPTURE_EN
    logic [63:0] cap_ops, cap_id, cap_s3;
`endif

    always #5 clk = ~clk;

    // Model of the exercised logic_ops circuit, with an optional OR stuck-at-0 fault.
    function automatic logic [3:0] logic_ops(input logic [3:0] v, input logic stuck);
        logic a1, a2, o;
        a1 = v[3] & v[2];
        a2 = v[1] & v[0];
        o  = (a1 | a2) & ~stuck;
        return {a1, a2, o, ~v[0]};
    endfunction

    always_comb begin
        resp_ops = logic_ops(stim_ops, ops_stuck);
        resp_id  = id_invert ? ~stim_id : stim_id;
        resp_s3  = stim_s3;
    end

    tt_sweep_checker #(.N_IN(4), .N_OUT(4), .SETTLE(1), .GOLDEN(GOLDEN_OPS)) u_ops (
        .clk(clk), .rst(rst), .start(start), .stim(stim_ops), .resp(resp_ops),
        .busy(busy_ops), .done(done_ops), .pass(pass_ops), .mismatch_count(mc_ops),
        .first_fail_valid(ffv_ops), .first_fail_idx(ffi_ops)
`ifdef TT_CAPTURE_EN
        , .captured_table(cap_ops)
`endif
    );

    tt_sweep_checker #(.N_IN(4), .N_OUT(4), .SETTLE(1), .GOLDEN(GOLDEN_ID)) u_id (
        .clk(clk), .rst(rst), .start(start), .stim(stim_id), .resp(resp_id),
        .busy(busy_id), .done(done_id), .pass(pass_id), .mismatch_count(mc_id),
        .first_fail_valid(ffv_id), .first_fail_idx(ffi_id)
`ifdef TT_CAPTURE_EN
        , .captured_table(cap_id)
`endif
    );

    tt_sweep_checker #(.N_IN(4), .N_OUT(4), .SETTLE(3), .GOLDEN(GOLDEN_ID)) u_s3 (
        .clk(clk), .rst(rst), .start(start), .stim(stim_s3), .resp(resp_s3),
        .busy(busy_s3), .done(done_s3), .pass(pass_s3), .mismatch_count(mc_s3),
        .first_fail_valid(ffv_s3), .first_fail_idx(ffi_s3)
`ifdef TT_CAPTURE_EN
        , .captured_table(cap_s3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " ops stim"}, 64'(stim_ops), 64'd0);
        check({tag, " ops busy"}, 64'(busy_ops), 64'd0);
        check({tag, " ops done"}, 64'(done_ops), 64'd0);
        check({tag, " ops pass"}, 64'(pass_ops), 64'd0);
        check({tag, " ops mc"},   64'(mc_ops),   64'd0);
        check({tag, " ops ffv"},  64'(ffv_ops),  64'd0);
        check({tag, " ops ffi"},  64'(ffi_ops),  64'd0);
        check({tag, " id busy"},  64'(busy_id),  64'd0);
        check({tag, " s3 busy"},  64'(busy_s3),  64'd0);
`ifdef TT_CAPTURE_EN
        check({tag, " ops cap"},  cap_ops,       64'd0);
`endif
    endtask

    // Start a sweep on all instances and follow it cycle by cycle.
    // busy_start_at: cycle index at which start is pulsed again while busy.
    // rst_at: cycle index at which rst is raised and the sweep abandoned.
    task automatic run_sweep(input int busy_start_at, input int rst_at);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("clr ops mc",   64'(mc_ops),   64'd0);
                check("clr ops ffv",  64'(ffv_ops),  64'd0);
                check("clr ops ffi",  64'(ffi_ops),  64'd0);
                check("clr ops done", 64'(done_ops), 64'd0);
                check("clr ops pass", 64'(pass_ops), 64'd0);
                check("clr id mc",    64'(mc_id),    64'd0);
            end
            check($sformatf("ops stim k%0d", k), 64'(stim_ops), 64'(k >> 1));
            check($sformatf("s3 stim k%0d", k),  64'(stim_s3),  64'(k >> 2));
            check($sformatf("ops busy k%0d", k), 64'(busy_ops), 64'd1);
            check($sformatf("ops done k%0d", k), 64'(done_ops), 64'd0);
            if (k == rst_at) begin
                rst = 1'b1;
                return;
            end
            start = (k == busy_start_at);
        end
        start = 1'b0;
        @(negedge clk);
        check("ops done end", 64'(done_ops), 64'd1);
        check("ops busy end", 64'(busy_ops), 64'd0);
        check("ops stim end", 64'(stim_ops), 64'd15);
        check("id done end",  64'(done_id),  64'd1);
    endtask

    // Follow the SETTLE=3 instance to completion (done at 64 edges after start edge).
    task automatic finish_s3();
        for (int k = 33; k <= 64; k++) begin
            @(negedge clk);
            if (k == 63) check("s3 done early", 64'(done_s3), 64'd0);
        end
        check("s3 done", 64'(done_s3), 64'd1);
        check("s3 pass", 64'(pass_s3), 64'd1);
        check("s3 mc",   64'(mc_s3),   64'd0);
        check("ops done hold", 64'(done_ops), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        id_invert = 1'b0;
        ops_stuck = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        // Sweep 1: loopback on identity, correct logic_ops DUT.
        run_sweep(-1, -1);
        check("s1 id pass", 64'(pass_id), 64'd1);
        check("s1 id mc",   64'(mc_id),   64'd0);
        check("s1 id ffv",  64'(ffv_id),  64'd0);
        check("s1 ops pass", 64'(pass_ops), 64'd1);
        check("s1 ops mc",   64'(mc_ops),   64'd0);
        finish_s3();

        // Sweep 2: from DONE, OR stuck at 0, inverted loopback, start pulsed during vector 3.
        ops_stuck = 1'b1;
        id_invert = 1'b1;
        run_sweep(6, -1);
        check("s2 ops pass", 64'(pass_ops), 64'd0);
        check("s2 ops mc",   64'(mc_ops),   64'd7);
        check("s2 ops ffv",  64'(ffv_ops),  64'd1);
        check("s2 ops ffi",  64'(ffi_ops),  64'd3);
        check("s2 id pass",  64'(pass_id),  64'd0);
        check("s2 id mc",    64'(mc_id),    64'd16);
        check("s2 id ffv",   64'(ffv_id),   64'd1);
        check("s2 id ffi",   64'(ffi_id),   64'd0);
`ifdef TT_CAPTURE_EN
        check("s2 id cap",   cap_id,        64'h0123_4567_89AB_CDEF);
`endif
        finish_s3();

        // Sweep 3: from DONE with stale failures, rst during vector 7.
        ops_stuck = 1'b0;
        id_invert = 1'b0;
        run_sweep(-1, 14);
        @(negedge clk);
        check_reset("mid rst");
        rst = 1'b0;

        // Sweep 4: fresh sweep after reset restarts at vector 0 with a clean count.
        run_sweep(-1, -1);
        check("s4 ops pass", 64'(pass_ops), 64'd1);
        check("s4 ops mc",   64'(mc_ops),   64'd0);
        check("s4 ops ffv",  64'(ffv_ops),  64'd0);
        finish_s3();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
